// File: rtl/decoder_pkg.sv
// Shared encodings for the instruction decoder: op classes, ALU codes, operand select formats.
package decoder_pkg;

  typedef enum logic [1:0] {
    OpData   = 2'b00,
    OpMem    = 2'b01,
    OpBranch = 2'b10,
    OpNop    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    AluAdd   = 3'b000,
    AluSub   = 3'b001,
    AluAnd   = 3'b010,
    AluOrr   = 3'b011,
    AluMul   = 3'b100,
    AluMov   = 3'b101,
    AluMovhi = 3'b110
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ImmDp     = 2'b00,
    ImmMem    = 2'b01,
    ImmBranch = 2'b10
  } imm_src_e;

  typedef enum logic [1:0] {
    RegSrcDp     = 2'b00,
    RegSrcBranch = 2'b01,
    RegSrcStr    = 2'b10
  } reg_src_e;

  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdSub = 4'b0001;
  localparam logic [3:0] CmdAdd = 4'b0010;
  localparam logic [3:0] CmdCmp = 4'b1010;
  localparam logic [3:0] CmdOrr = 4'b1100;
  localparam logic [3:0] CmdMov = 4'b1110;

  localparam logic [3:0] MUL_MARK   = 4'b1001;
  localparam logic [3:0] MOVHI_MARK = 4'b1110;

  localparam logic [3:0] PcIndex = 4'b1111;

  // Full registered control word.
  typedef struct packed {
    logic [2:0] alu_control;
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       no_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
  } ctrl_t;

  // Commands whose carry/overflow results are architecturally visible.
  function automatic logic is_arith(logic [3:0] cmd);
    return (cmd == CmdAdd) || (cmd == CmdSub) || (cmd == CmdCmp);
  endfunction

endpackage

// File: rtl/decoder_main_dec.sv
// Main decoder: instruction class to datapath steering; ALU detail is resolved by the parent.
module main_dec
  import decoder_pkg::*;
(
  input  logic [1:0] op_i,
  input  logic       imm_i,
  input  logic       s_i,
  output logic [1:0] reg_src_o,
  output logic [1:0] imm_src_o,
  output logic       alu_src_o,
  output logic       mem_to_reg_o,
  output logic       reg_w_o,
  output logic       mem_w_o,
  output logic       branch_o,
  output logic       alu_op_o
);

  always_comb begin
    reg_src_o    = RegSrcDp;
    imm_src_o    = ImmDp;
    alu_src_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_w_o      = 1'b0;
    mem_w_o      = 1'b0;
    branch_o     = 1'b0;
    alu_op_o     = 1'b0;
    unique case (op_i)
      OpData: begin
        alu_src_o = imm_i;
        reg_w_o   = 1'b1;
        alu_op_o  = 1'b1;
      end
      OpMem: begin
        imm_src_o = ImmMem;
        alu_src_o = 1'b1;
        if (s_i) begin
          mem_to_reg_o = 1'b1;
          reg_w_o      = 1'b1;
        end else begin
          reg_src_o = RegSrcStr;
          mem_w_o   = 1'b1;
        end
      end
      OpBranch: begin
        reg_src_o = RegSrcBranch;
        imm_src_o = ImmBranch;
        alu_src_o = 1'b1;
        branch_o  = 1'b1;
      end
      OpNop: begin
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/decoder.sv
// Instruction decoder: class decode via main_dec, ALU/flag/PC decode here, one-cycle registered output.
module decoder
  import decoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Mul,
  input  logic [3:0] movhi,
  output logic [2:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       NoWrite,
  output logic       MemtoReg,
  output logic       ALUSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);

  logic [3:0] cmd;
  logic       s_bit;
  logic [1:0] md_reg_src, md_imm_src;
  logic       md_alu_src, md_mem_to_reg, md_reg_w, md_mem_w, md_branch, md_alu_op;
  logic [2:0] dp_alu;
  logic       dp_known;
  logic       reg_w_next;
  ctrl_t      ctrl_d, ctrl_q;

  assign cmd   = Funct[4:1];
  assign s_bit = Funct[0];

  main_dec u_main_dec (
    .op_i         (Op),
    .imm_i        (Funct[5]),
    .s_i          (s_bit),
    .reg_src_o    (md_reg_src),
    .imm_src_o    (md_imm_src),
    .alu_src_o    (md_alu_src),
    .mem_to_reg_o (md_mem_to_reg),
    .reg_w_o      (md_reg_w),
    .mem_w_o      (md_mem_w),
    .branch_o     (md_branch),
    .alu_op_o     (md_alu_op)
  );

  // Marker-qualified ops take precedence over the plain cmd table.
  always_comb begin
    dp_alu   = AluAdd;
    dp_known = 1'b1;
    if (Mul == MUL_MARK && cmd == CmdAnd) begin
      dp_alu = AluMul;
    end else if (cmd == CmdMov && movhi == MOVHI_MARK) begin
      dp_alu = AluMovhi;
    end else begin
      case (cmd)
        CmdMov:  dp_alu = AluMov;
        CmdAdd:  dp_alu = AluAdd;
        CmdSub:  dp_alu = AluSub;
        CmdCmp:  dp_alu = AluSub;
        CmdAnd:  dp_alu = AluAnd;
        CmdOrr:  dp_alu = AluOrr;
        default: begin
          dp_alu   = AluAdd;
          dp_known = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ctrl_d            = '0;
    ctrl_d.reg_src    = md_reg_src;
    ctrl_d.imm_src    = md_imm_src;
    ctrl_d.alu_src    = md_alu_src;
    ctrl_d.mem_to_reg = md_mem_to_reg;
    ctrl_d.mem_w      = md_mem_w;
    reg_w_next        = md_reg_w;
    if (md_alu_op) begin
      ctrl_d.alu_control = dp_alu;
      ctrl_d.no_write    = (cmd == CmdCmp);
      ctrl_d.flag_w      = {s_bit, s_bit & is_arith(cmd)};
      reg_w_next         = md_reg_w & dp_known & (cmd != CmdCmp);
    end
    ctrl_d.reg_w = reg_w_next;
    // A register write to the PC index redirects fetch just like a branch.
    ctrl_d.pcs   = ((Rd == PcIndex) & reg_w_next) | md_branch;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign ALUControl = ctrl_q.alu_control;
  assign FlagW      = ctrl_q.flag_w;
  assign PCS        = ctrl_q.pcs;
  assign RegW       = ctrl_q.reg_w;
  assign MemW       = ctrl_q.mem_w;
  assign NoWrite    = ctrl_q.no_write;
  assign MemtoReg   = ctrl_q.mem_to_reg;
  assign ALUSrc     = ctrl_q.alu_src;
  assign ImmSrc     = ctrl_q.imm_src;
  assign RegSrc     = ctrl_q.reg_src;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed cases, reset behaviour and randomized model comparison.
module tb_decoder;

  logic       clk, reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd, Mul, movhi;
  logic [2:0] ALUControl;
  logic [1:0] FlagW, ImmSrc, RegSrc;
  logic       PCS, RegW, MemW, NoWrite, MemtoReg, ALUSrc;
  logic [14:0] dut_vec;

  int n_checks = 0;
  int n_pass   = 0;

  decoder dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .Mul        (Mul),
    .movhi      (movhi),
    .ALUControl (ALUControl),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .NoWrite    (NoWrite),
    .MemtoReg   (MemtoReg),
    .ALUSrc     (ALUSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc)
  );

  assign dut_vec = {ALUControl, FlagW, PCS, RegW, MemW, NoWrite, MemtoReg, ALUSrc, ImmSrc, RegSrc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected control word straight from the instruction-class rules.
  function automatic logic [14:0] model(input logic [1:0] op, input logic [5:0] funct,
                                        input logic [3:0] rd, input logic [3:0] mul,
                                        input logic [3:0] mh);
    logic [2:0] alu = 3'd0;
    logic [1:0] fw = 2'd0, is = 2'd0, rs = 2'd0;
    logic pcs = 0, rw = 0, mw = 0, nw = 0, m2r = 0, as = 0;
    logic [3:0] cmd = funct[4:1];
    logic s = funct[0];
    case (op)
      2'd0: begin
        as = funct[5];
        rw = 1;
        if (mul == 4'd9 && cmd == 4'd0)       alu = 3'd4;
        else if (cmd == 4'd14 && mh == 4'd14) alu = 3'd6;
        else if (cmd == 4'd14)                alu = 3'd5;
        else if (cmd == 4'd2)                 alu = 3'd0;
        else if (cmd == 4'd1)                 alu = 3'd1;
        else if (cmd == 4'd10)                alu = 3'd1;
        else if (cmd == 4'd0)                 alu = 3'd2;
        else if (cmd == 4'd12)                alu = 3'd3;
        else                                  rw  = 0;
        nw = (cmd == 4'd10);
        if (nw) rw = 0;
        fw = {s, s && (cmd == 4'd2 || cmd == 4'd1 || cmd == 4'd10)};
        pcs = (rd == 4'd15) && rw;
      end
      2'd1: begin
        as = 1;
        is = 2'd1;
        if (s) begin m2r = 1; rw = 1; end
        else begin rs = 2'd2; mw = 1; end
        pcs = (rd == 4'd15) && rw;
      end
      2'd2: begin
        rs = 2'd1; is = 2'd2; as = 1; pcs = 1;
      end
      default: ;
    endcase
    return {alu, fw, pcs, rw, mw, nw, m2r, as, is, rs};
  endfunction

  task automatic drive(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                       input logic [3:0] mul, input logic [3:0] mh);
    @(negedge clk);
    Op = op; Funct = funct; Rd = rd; Mul = mul; movhi = mh;
  endtask

  task automatic step(input string tag, input logic [1:0] op, input logic [5:0] funct,
                      input logic [3:0] rd, input logic [3:0] mul, input logic [3:0] mh);
    logic [14:0] exp;
    drive(op, funct, rd, mul, mh);
    exp = model(op, funct, rd, mul, mh);
    @(posedge clk);
    #1;
    check(tag, dut_vec, exp);
  endtask

  initial begin
    reset = 1'b1;
    Op = 2'b00; Funct = 6'b000100; Rd = 4'd0; Mul = 4'd0; movhi = 4'd0;
    #2;
    check("reset_state", dut_vec, 15'd0);
    @(posedge clk);
    #1;
    check("reset_holds_over_edge", dut_vec, 15'd0);
    @(negedge clk);
    reset = 1'b0;

    step("add", 2'b00, 6'b000100, 4'd0, 4'd0, 4'd0);
    check("add_alu", ALUControl, 3'b000);
    check("add_regw", RegW, 1'b1);
    check("add_alusrc", ALUSrc, 1'b0);
    check("add_flagw", FlagW, 2'b00);
    check("add_pcs", PCS, 1'b0);

    step("sub", 2'b00, 6'b000010, 4'd0, 4'd0, 4'd0);
    check("sub_alu", ALUControl, 3'b001);
    step("mul", 2'b00, 6'b000000, 4'd0, 4'b1001, 4'd0);
    check("mul_alu", ALUControl, 3'b100);
    check("mul_regw", RegW, 1'b1);

    step("movhi", 2'b00, 6'b011101, 4'd0, 4'd0, 4'b1110);
    check("movhi_alu", ALUControl, 3'b110);
    check("movhi_flagw", FlagW, 2'b10);
    step("mov", 2'b00, 6'b011101, 4'd0, 4'd0, 4'b0000);
    check("mov_alu", ALUControl, 3'b101);

    step("cmp", 2'b00, 6'b010101, 4'd3, 4'd0, 4'd0);
    check("cmp_nowrite", NoWrite, 1'b1);
    check("cmp_flagw", FlagW, 2'b11);
    step("dp_unknown", 2'b00, 6'b101011, 4'd15, 4'd0, 4'd0);
    check("dp_unknown_regw", RegW, 1'b0);
    step("add_to_pc", 2'b00, 6'b100100, 4'd15, 4'd0, 4'd0);
    check("add_to_pc_pcs", PCS, 1'b1);

    step("ldr", 2'b01, 6'b000001, 4'd2, 4'd0, 4'd0);
    check("ldr_memtoreg", MemtoReg, 1'b1);
    check("ldr_regw", RegW, 1'b1);
    check("ldr_immsrc", ImmSrc, 2'b01);
    step("str", 2'b01, 6'b000000, 4'd2, 4'd0, 4'd0);
    check("str_memw", MemW, 1'b1);
    check("str_regw", RegW, 1'b0);
    check("str_regsrc", RegSrc, 2'b10);

    step("branch", 2'b10, 6'b000000, 4'b1111, 4'd0, 4'd0);
    check("branch_pcs", PCS, 1'b1);
    check("branch_immsrc", ImmSrc, 2'b10);
    check("branch_regw", RegW, 1'b0);
    step("nop", 2'b11, 6'b111111, 4'd15, 4'b1001, 4'b1110);
    check("nop_all_zero", dut_vec, 15'd0);

    // Unused fields driven unknown must not reach the outputs.
    step("ldr_x", 2'b01, 6'bxxxxx1, 4'd1, 4'bxxxx, 4'bxxxx);
    step("str_x", 2'b01, 6'bxxxxx0, 4'hx, 4'bxxxx, 4'bxxxx);
    step("branch_x", 2'b10, 6'bxxxxxx, 4'hx, 4'bxxxx, 4'bxxxx);
    step("nop_x", 2'b11, 6'bxxxxxx, 4'hx, 4'bxxxx, 4'bxxxx);

    // Reset between edges clears at once and discards the pending decode.
    step("pre_reset", 2'b01, 6'b000001, 4'd15, 4'd0, 4'd0);
    #3;
    reset = 1'b1;
    #1;
    check("reset_async", dut_vec, 15'd0);
    drive(2'b00, 6'b011101, 4'd0, 4'd0, 4'b1110);
    @(posedge clk);
    #1;
    check("reset_discard", dut_vec, 15'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", dut_vec, model(2'b00, 6'b011101, 4'd0, 4'd0, 4'b1110));

    for (int i = 0; i < 400; i++) begin
      logic [1:0] op;
      logic [5:0] funct;
      logic [3:0] rd, mul, mh;
      op    = 2'($urandom_range(3, 0));
      funct = 6'($urandom);
      rd    = ($urandom_range(3, 0) == 0) ? 4'hF : 4'($urandom);
      mul   = ($urandom_range(1, 0) == 0) ? 4'b1001 : 4'($urandom);
      mh    = ($urandom_range(1, 0) == 0) ? 4'b1110 : 4'($urandom);
      step("random", op, funct, rd, mul, mh);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 The interface SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-002 The port clk SHALL be a 1-bit input: rising-edge clock.
REQ-003 The port reset SHALL be a 1-bit input: asynchronous, active-high clear.
REQ-004 The port Op SHALL be a 2-bit input: instruction class (00 data-proc, 01 memory, 10 branch, 11 reserved).
REQ-005 The port Funct SHALL be a 6-bit input: [5]=I (immediate), [4:1]=cmd, [0]=S (set flags; for memory, 1=LDR, 0=STR).
REQ-006 The port Rd SHALL be a 4-bit input: destination register index.
REQ-007 The port Mul SHALL be a 4-bit input: multiply marker; 4'b1001 selects MUL.
REQ-008 The port movhi SHALL be a 4-bit input: MOVHI marker; 4'b1110 selects MOVHI.
REQ-009 The following SHALL be registered outputs:
- ALUControl (3 bits): ALU operation.
- FlagW (2 bits): [1] NZ write, [0] CV write.
- PCS, RegW, MemW, NoWrite, MemtoReg, ALUSrc (1 bit each): PC source, reg write, mem write, suppress write, load path, immediate operand.
- ImmSrc (2 bits): immediate format.
- RegSrc (2 bits): register-read select.

Function
REQ-010 All outputs SHALL be combinationally decoded from the current inputs and registered on the rising clk edge; latency is exactly 1 cycle and there is no handshake.
REQ-011 Op=00 SHALL give RegSrc=00, ImmSrc=00, ALUSrc=Funct[5], MemtoReg=0, MemW=0, RegW=~NoWrite.
REQ-012 Op=01 with Funct[0]=1 (LDR) SHALL give RegSrc=00, ImmSrc=01, ALUSrc=1, MemtoReg=1, RegW=1, MemW=0, ALUControl=000, FlagW=00.
REQ-013 Op=01 with Funct[0]=0 (STR) SHALL give RegSrc=10, ImmSrc=01, ALUSrc=1, MemtoReg=0, RegW=0, MemW=1, ALUControl=000, FlagW=00.
REQ-014 Op=10 (branch) SHALL give RegSrc=01, ImmSrc=10, ALUSrc=1, RegW=0, MemW=0, MemtoReg=0, ALUControl=000, FlagW=00, PCS=1.
REQ-015 Op=11 SHALL drive all outputs to 0 (NOP).
REQ-016 Data-proc ALUControl, in priority order:
- Mul==1001 and cmd=0000: 100 (MUL).
- cmd=1110 and movhi==1110: 110 (MOVHI).
- cmd=1110: 101 (MOV).
- cmd=0010: 000 (ADD).
- cmd=0001: 001 (SUB).
- cmd=1010: 001 (CMP).
- cmd=0000: 010 (AND).
- cmd=1100: 011 (ORR).
- Any other cmd: 000, with RegW=0.
REQ-017 NoWrite SHALL be 1 only for data-proc cmd=1010 and 0 otherwise.
REQ-018 For data-proc, FlagW[1] SHALL equal S; FlagW[0] SHALL equal S AND (ADD, SUB or CMP).
REQ-019 PCS SHALL equal (Rd==4'b1111 AND RegW_next) OR branch.
REQ-020 X or Z on Funct bits that are not used for the decoded class SHALL NOT propagate to the outputs; unused fields SHALL be ignored.

Reset
REQ-021 While reset=1, all outputs SHALL be 0 immediately, independent of clk.
REQ-022 After reset deasserts, the first rising edge SHALL load the decoded values; a reset asserted mid-stream SHALL discard the pending decode.

Structure
REQ-023 A shared package SHALL define the Op class constants, ALUControl codes (ADD 000, SUB 001, AND 010, ORR 011, MUL 100, MOV 101, MOVHI 110), ImmSrc/RegSrc encodings, and MUL_MARK=1001 and MOVHI_MARK=1110.
REQ-024 One combinational sub-module, main_dec (Op/Funct[5]/Funct[0] to RegSrc, ImmSrc, ALUSrc, MemtoReg, RegW, MemW, branch, alu_op), SHALL be used; ALU decode, PC logic and the output register SHALL reside in decoder.

Verification
REQ-025 ADD: Op=00, Funct=000100, Rd=0, Mul=0, movhi=0, with one edge, SHALL give ALUControl=000, RegW=1, ALUSrc=0, FlagW=00, PCS=0.
REQ-026 SUB then MUL: Funct=000010 SHALL give ALUControl=001; then Funct=000000 with Mul=1001 SHALL give ALUControl=100 and RegW=1.
REQ-027 MOVHI: Funct=011101 with movhi=1110 SHALL give ALUControl=110 and FlagW=10; with movhi=0000 it SHALL give ALUControl=101.
REQ-028 Memory: Op=01, Funct=000001 SHALL give MemtoReg=1, RegW=1, ImmSrc=01; Op=01, Funct=000000 SHALL give MemW=1, RegW=0, RegSrc=10.
REQ-029 Branch/NOP: Op=10, Rd=1111 SHALL give PCS=1, ImmSrc=10, RegW=0; Op=11 SHALL give all outputs 0.
REQ-030 Reset: asserting reset between clock edges SHALL zero all outputs at once; the first edge after release SHALL restore the decode.
